// File: rtl/hwpe_tcdm_responder.sv
// Arbitrates several HWPE TCDM ports onto one fixed-latency memory port and routes responses back.
// Define HWPE_TCDM_RESP_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module hwpe_tcdm_responder #(
  parameter int unsigned N_PORTS = 3,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N_PORTS-1:0]                tcdm_req_i,
  output logic [N_PORTS-1:0]                tcdm_gnt_o,
  input  logic [N_PORTS-1:0][ADDR_W-1:0]    tcdm_add_i,
  input  logic [N_PORTS-1:0]                tcdm_wen_i,
  input  logic [N_PORTS-1:0][DATA_W/8-1:0]  tcdm_be_i,
  input  logic [N_PORTS-1:0][DATA_W-1:0]    tcdm_data_i,
  output logic [N_PORTS-1:0][DATA_W-1:0]    tcdm_r_data_o,
  output logic [N_PORTS-1:0]                tcdm_r_valid_o,
  output logic                              mem_req_o,
  input  logic                              mem_gnt_i,
  output logic [ADDR_W-1:0]                 mem_add_o,
  output logic                              mem_wen_o,
  output logic [DATA_W/8-1:0]               mem_be_o,
  output logic [DATA_W-1:0]                 mem_wdata_o,
  input  logic [DATA_W-1:0]                 mem_rdata_i
);

  localparam int unsigned      IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(N_PORTS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_PORTS - 1);

  logic [IDX_W-1:0]              rr_ptr_reg;
  logic [N_PORTS-1:0][IDX_W-1:0] cand;
  logic [IDX_W-1:0]              winner;
  logic                          handshake;
  logic                          resp_pending_reg;
  logic [IDX_W-1:0]              resp_idx_reg;

  // cand[i] is the port visited i-th when scanning upward from the pointer
  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum      = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
      assign cand[gi] = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : sum[IDX_W-1:0];
    end
  endgenerate

  // Descending scan so the earliest requesting candidate overwrites later ones
  always_comb begin
    winner = cand[0];
    for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
      if (tcdm_req_i[cand[i]]) winner = cand[i];
    end
  end

  assign mem_req_o   = |tcdm_req_i;
  assign handshake   = mem_req_o & mem_gnt_i;
  assign mem_add_o   = tcdm_add_i[winner];
  assign mem_wen_o   = tcdm_wen_i[winner];
  assign mem_be_o    = tcdm_be_i[winner];
  assign mem_wdata_o = tcdm_data_i[winner];

`ifdef HWPE_TCDM_RESP_FIXED_PRIO_EN
  assign rr_ptr_reg = '0;
`else
  logic [IDX_W-1:0] rr_ptr_next;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (handshake) rr_ptr_next = (winner == LAST) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_reg <= '0;
    else       rr_ptr_reg <= rr_ptr_next;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_pending_reg <= 1'b0;
      resp_idx_reg     <= '0;
    end else begin
      resp_pending_reg <= handshake;
      if (handshake) resp_idx_reg <= winner;
    end
  end

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign tcdm_gnt_o[gi]     = handshake & (winner == IDX_W'(gi));
      assign tcdm_r_valid_o[gi] = resp_pending_reg & (resp_idx_reg == IDX_W'(gi));
      assign tcdm_r_data_o[gi]  = mem_rdata_i;
    end
  endgenerate

endmodule

// File: tb/tb_hwpe_tcdm_responder.sv
// Directed plus randomized bench for hwpe_tcdm_responder against a queue-free behavioural model.
// Honours HWPE_TCDM_RESP_FIXED_PRIO_EN in the reference arbitration rule.
module tb_hwpe_tcdm_responder;

  localparam int N = 3;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic [N-1:0]          tcdm_req_i = '0;
  logic [N-1:0]          tcdm_gnt_o;
  logic [N-1:0][31:0]    tcdm_add_i = '0;
  logic [N-1:0]          tcdm_wen_i = '1;
  logic [N-1:0][3:0]     tcdm_be_i = '0;
  logic [N-1:0][31:0]    tcdm_data_i = '0;
  logic [N-1:0][31:0]    tcdm_r_data_o;
  logic [N-1:0]          tcdm_r_valid_o;
  logic                  mem_req_o;
  logic                  mem_gnt_i = 1'b0;
  logic [31:0]           mem_add_o;
  logic                  mem_wen_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i = '0;

  hwpe_tcdm_responder #(.N_PORTS(N), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tcdm_req_i(tcdm_req_i), .tcdm_gnt_o(tcdm_gnt_o), .tcdm_add_i(tcdm_add_i),
    .tcdm_wen_i(tcdm_wen_i), .tcdm_be_i(tcdm_be_i), .tcdm_data_i(tcdm_data_i),
    .tcdm_r_data_o(tcdm_r_data_o), .tcdm_r_valid_o(tcdm_r_valid_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_add_o(mem_add_o),
    .mem_wen_o(mem_wen_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  // reference model state
  int          ptr = 0;
  bit          pend = 1'b0;
  int          pidx = 0;
  bit          pend_read = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [N-1:0] last_gnt = '0;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic int model_winner();
    int s = 0;
`ifndef HWPE_TCDM_RESP_FIXED_PRIO_EN
    s = ptr;
`endif
    for (int i = 0; i < N; i++) begin
      if (tcdm_req_i[(s + i) % N]) return (s + i) % N;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check combinational/registered outputs mid-cycle, then advance the model.
  task automatic cycle();
    int          w;
    logic        any, hs, wen;
    logic [N-1:0] eg, ev;
    logic [31:0] a, d, old;
    logic [3:0]  be;
    #1;
    any = |tcdm_req_i;
    w   = model_winner();
    hs  = any && mem_gnt_i;
    eg  = hs ? N'(1 << w) : '0;
    ev  = pend ? N'(1 << pidx) : '0;
    chk("gnt", 32'(tcdm_gnt_o), 32'(eg));
    chk("r_valid", 32'(tcdm_r_valid_o), 32'(ev));
    chk("mem_req", 32'(mem_req_o), 32'(any));
    if (pend && pend_read) chk("r_data", tcdm_r_data_o[pidx], exp_rdata);
    a = tcdm_add_i[w]; wen = tcdm_wen_i[w]; be = tcdm_be_i[w]; d = tcdm_data_i[w];
    if (any) begin
      chk("mem_add", mem_add_o, a);
      chk("mem_wen", 32'(mem_wen_o), 32'(wen));
      chk("mem_be", 32'(mem_be_o), 32'(be));
      chk("mem_wdata", mem_wdata_o, d);
    end
    @(posedge clk_i);
    if (!rst_i) begin
      last_gnt = eg;
      pend     = hs;
      if (hs) begin
        pidx      = w;
        ptr       = (w + 1) % N;
        pend_read = wen;
        if (wen) exp_rdata = rd(a);
        else begin
          old = rd(a);
          for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = d[8*b +: 8];
          mem[a] = old;
        end
      end
      mem_rdata_i = (hs && wen) ? exp_rdata : $urandom;
    end else begin
      last_gnt = '0;
    end
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    pend  = 1'b0;
    ptr   = 0;
  endtask

  initial begin
    logic [N-1:0] rot [3];
    logic [31:0]  held;
    rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100;
    for (int k = 0; k < N; k++) tcdm_add_i[k] = 32'h100 + 32'(k * 4);

    // Reset with all ports requesting and memory granting: no responses, no state change
    @(negedge clk_i);
    tcdm_req_i = 3'b111; mem_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    rst_i = 1'b0;

    // Round-robin rotation starting from port 0 after reset
    for (int i = 0; i < 6; i++) begin
`ifndef HWPE_TCDM_RESP_FIXED_PRIO_EN
      #1 chk("rr_seq", 32'(tcdm_gnt_o), 32'(rot[i % 3]));
`endif
      cycle();
    end
    tcdm_req_i = '0;
    cycle();

    // Back-pressure on port 1
    tcdm_req_i = 3'b010; tcdm_add_i[1] = 32'h0000_0088; mem_gnt_i = 1'b0;
    held = tcdm_add_i[1];
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_gnt_i = 1'b1;
      #1 chk("bp_add_stable", mem_add_o, held);
      cycle();
    end
    tcdm_req_i = '0;
    cycle();

    // Port 2 read of 0x40 returning DEADBEEF, then a partial write from port 0
    mem[32'h40] = 32'hDEAD_BEEF;
    tcdm_req_i = 3'b100; tcdm_add_i[2] = 32'h40; tcdm_wen_i[2] = 1'b1;
    cycle();
    tcdm_req_i = 3'b001; tcdm_add_i[0] = 32'h44; tcdm_wen_i[0] = 1'b0;
    tcdm_be_i[0] = 4'b0011; tcdm_data_i[0] = 32'h1234_5678;
    #1 chk("route_valid", 32'(tcdm_r_valid_o), 32'h4);
    chk("route_data", tcdm_r_data_o[2], 32'hDEAD_BEEF);
    cycle();
    tcdm_req_i = '0;
    cycle();

    // Reset asserted the cycle after a grant to port 1: response is dropped
    tcdm_req_i = 3'b010; tcdm_wen_i[1] = 1'b1;
    cycle();
    tcdm_req_i = '0;
    apply_reset();
    cycle();
    rst_i = 1'b0;
    cycle();

    // Fixed priority starvation check (meaningful in both modes via the model)
    tcdm_req_i = 3'b110;
    for (int i = 0; i < 3; i++) cycle();
    tcdm_req_i = '0;
    cycle();

    // Randomized traffic; ungranted ports keep their request stable
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!tcdm_req_i[k] || last_gnt[k]) begin
          tcdm_req_i[k]  = ($urandom_range(0, 2) != 0);
          tcdm_add_i[k]  = 32'($urandom_range(0, 15)) << 2;
          tcdm_wen_i[k]  = $urandom_range(0, 1) != 0;
          tcdm_be_i[k]   = 4'($urandom);
          tcdm_data_i[k] = $urandom;
        end
      end
      mem_gnt_i = ($urandom_range(0, 3) != 0);
      if (c == 200) apply_reset();
      if (c == 202) rst_i = 1'b0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
